e203_sysper_icb2apb: RTL and testbench

ICB-to-APB bridge that sits directly downstream of the subsystem's sysper ICB master port. It is the slave that consumes sysper commands and produces sysper responses, replacing the cmd-to-rsp loopback tie-off at SoC top. Each ICB command becomes one APB3/APB4 transfer. The APB response is returned as a single ICB response. One transfer is outstanding at a time.

---
 rtl/e203_sysper_icb2apb.sv | 173 +++++++++++++++++
 tb/tb_e203_sysper_icb2apb.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/e203_sysper_icb2apb.sv
// ICB-to-APB bridge for the sysper port.
//
// Each accepted ICB command becomes one APB transfer (SETUP, then ACCESS until
// pready). The APB result comes back as one ICB response. Only one transfer is
// in flight at a time. A new command may be accepted in the same cycle that the
// previous response is taken, which gives one transfer every 3 cycles.
//
// Optional feature: define E203_ICB2APB_TIMEOUT_EN to abort an ACCESS phase
// that waits too long for pready. The abort returns rsp_err=1 and rdata=0.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   icb_cmd_*             ICB command channel (valid/ready, addr, read, wdata, wmask)
//   icb_rsp_*             ICB response channel (valid/ready, err, rdata)
//   apb_*                 APB3/APB4 master (pprot tied to 3'b000)
module e203_sysper_icb2apb #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int TO_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            icb_cmd_valid,
  output logic            icb_cmd_ready,
  input  logic [AW-1:0]   icb_cmd_addr,
  input  logic            icb_cmd_read,
  input  logic [DW-1:0]   icb_cmd_wdata,
  input  logic [DW/8-1:0] icb_cmd_wmask,
  output logic            icb_rsp_valid,
  input  logic            icb_rsp_ready,
  output logic            icb_rsp_err,
  output logic [DW-1:0]   icb_rsp_rdata,
  output logic [AW-1:0]   apb_paddr,
  output logic            apb_psel,
  output logic            apb_penable,
  output logic            apb_pwrite,
  output logic [DW-1:0]   apb_pwdata,
  output logic [DW/8-1:0] apb_pstrb,
  output logic [2:0]      apb_pprot,
  input  logic            apb_pready,
  input  logic [DW-1:0]   apb_prdata,
  input  logic            apb_pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RSP} state_t;

  state_t            state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [AW-1:0]     paddr_q, paddr_d;
  logic [DW-1:0]     pwdata_q, pwdata_d;
  logic [DW/8-1:0]   pstrb_q, pstrb_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic              cmd_hsk;
  logic              to_abort;

  assign icb_cmd_ready = (state_q == IDLE) | ((state_q == RSP) & icb_rsp_ready);
  assign cmd_hsk       = icb_cmd_valid & icb_cmd_ready;

`ifdef E203_ICB2APB_TIMEOUT_EN
  // Abort fires on the cycle whose increment would bring the count to all-ones,
  // so ACCESS lasts at most 2^TO_W-1 cycles without pready.
  localparam logic [TO_W-1:0] TO_LAST = {TO_W{1'b1}} - TO_W'(1);
  logic [TO_W-1:0] to_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 to_cnt_q <= '0;
    else if (state_q == SETUP)                  to_cnt_q <= '0;
    else if ((state_q == ACCESS) && !apb_pready) to_cnt_q <= to_cnt_q + TO_W'(1);
  end

  assign to_abort = (state_q == ACCESS) & ~apb_pready & (to_cnt_q == TO_LAST);
`else
  assign to_abort = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      IDLE: ;
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (apb_pready) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = apb_pslverr;
          rsp_rdata_d = pwrite_q ? '0 : apb_prdata;
          state_d     = RSP;
        end else if (to_abort) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (icb_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Command capture is shared by IDLE and the RSP overlap case.
    if (cmd_hsk) begin
      paddr_d   = icb_cmd_addr & ~AW'(3);
      pwrite_d  = ~icb_cmd_read;
      pwdata_d  = icb_cmd_read ? '0 : icb_cmd_wdata;
      pstrb_d   = icb_cmd_read ? '0 : icb_cmd_wmask;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      state_d   = SETUP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign apb_psel      = psel_q;
  assign apb_penable   = penable_q;
  assign apb_pwrite    = pwrite_q;
  assign apb_paddr     = paddr_q;
  assign apb_pwdata    = pwdata_q;
  assign apb_pstrb     = pstrb_q;
  assign apb_pprot     = 3'b000;
  assign icb_rsp_valid = rsp_valid_q;
  assign icb_rsp_err   = rsp_err_q;
  assign icb_rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_e203_sysper_icb2apb.sv
// Bench for e203_sysper_icb2apb: directed scenarios plus randomized
// transfers. The bench plays ICB master and APB slave at transaction level and
// predicts every APB/ICB observation from the command and slave behaviour.
module tb_e203_sysper_icb2apb;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO_W = 4;

  logic gclk = 1'b0;
  logic grst_n = 1'b0;
  always #5 gclk = ~gclk;

  logic          cmd_valid = 0, cmd_ready, cmd_read = 0;
  logic [31:0]   cmd_addr = 0, cmd_wdata = 0;
  logic [3:0]    cmd_wmask = 0;
  logic          rsp_valid, rsp_ready = 0, rsp_err;
  logic [31:0]   rsp_rdata, paddr, pwdata, prdata = 0;
  logic          psel, penable, pwrite, pready = 0, pslverr = 0;
  logic [3:0]    pstrb;
  logic [2:0]    pprot;

  e203_sysper_icb2apb #(.AW(AW), .DW(DW), .TO_W(TO_W)) dut (
    .clk(gclk), .rst_n(grst_n),
    .icb_cmd_valid(cmd_valid), .icb_cmd_ready(cmd_ready), .icb_cmd_addr(cmd_addr),
    .icb_cmd_read(cmd_read), .icb_cmd_wdata(cmd_wdata), .icb_cmd_wmask(cmd_wmask),
    .icb_rsp_valid(rsp_valid), .icb_rsp_ready(rsp_ready), .icb_rsp_err(rsp_err),
    .icb_rsp_rdata(rsp_rdata),
    .apb_paddr(paddr), .apb_psel(psel), .apb_penable(penable), .apb_pwrite(pwrite),
    .apb_pwdata(pwdata), .apb_pstrb(pstrb), .apb_pprot(pprot),
    .apb_pready(pready), .apb_prdata(prdata), .apb_pslverr(pslverr)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit chained = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // One ICB transfer. waits = ACCESS cycles with pready low before completion,
  // hold = cycles the response is backpressured, chain_next = present the next
  // command in the same cycle the response is taken.
  task automatic run_txn(input logic [31:0] addr, input logic rd, input logic [31:0] wdata,
                         input logic [3:0] wmask, input int waits, input logic [31:0] rdata,
                         input logic slverr, input int hold, input bit chain_next);
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_strb;
    e_addr  = addr & 32'hFFFF_FFFC;
    e_wdata = rd ? 32'h0 : wdata;
    e_strb  = rd ? 4'h0 : wmask;
    e_rdata = rd ? rdata : 32'h0;
    if (!chained) begin
      @(negedge gclk);
      chk("idle_cmd_ready", {31'b0, cmd_ready}, 1);
      chk("idle_psel", {31'b0, psel}, 0);
    end
    cmd_valid = 1; cmd_addr = addr; cmd_read = rd; cmd_wdata = wdata; cmd_wmask = wmask;
    @(negedge gclk);
    cmd_valid = 0; rsp_ready = 0; cmd_addr = $urandom; cmd_wdata = $urandom;
    chk("setup_psel", {31'b0, psel}, 1);
    chk("setup_penable", {31'b0, penable}, 0);
    chk("setup_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("setup_paddr", paddr, e_addr);
    chk("setup_pwrite", {31'b0, pwrite}, {31'b0, ~rd});
    chk("setup_pwdata", pwdata, e_wdata);
    chk("setup_pstrb", {28'b0, pstrb}, {28'b0, e_strb});
    chk("pprot", {29'b0, pprot}, 0);
    for (int i = 0; i <= waits; i++) begin
      @(negedge gclk);
      chk("access_psel", {31'b0, psel}, 1);
      chk("access_penable", {31'b0, penable}, 1);
      chk("access_paddr", paddr, e_addr);
      chk("access_pwdata", pwdata, e_wdata);
      chk("access_pstrb", {28'b0, pstrb}, {28'b0, e_strb});
      pready  = (i == waits);
      prdata  = (i == waits) ? rdata : $urandom;
      pslverr = (i == waits) ? slverr : 1'($urandom);
    end
    @(negedge gclk);
    pready = 0;
    chk("rsp_valid", {31'b0, rsp_valid}, 1);
    chk("rsp_err", {31'b0, rsp_err}, {31'b0, slverr});
    chk("rsp_rdata", rsp_rdata, e_rdata);
    chk("rsp_psel", {31'b0, psel}, 0);
    chk("rsp_penable", {31'b0, penable}, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge gclk);
      chk("hold_rsp_valid", {31'b0, rsp_valid}, 1);
      chk("hold_rsp_err", {31'b0, rsp_err}, {31'b0, slverr});
      chk("hold_rsp_rdata", rsp_rdata, e_rdata);
      chk("hold_cmd_ready", {31'b0, cmd_ready}, 0);
      chk("hold_psel", {31'b0, psel}, 0);
    end
    rsp_ready = 1;
    if (chain_next) begin
      chained = 1;
    end else begin
      @(negedge gclk);
      rsp_ready = 0;
      chk("done_rsp_valid", {31'b0, rsp_valid}, 0);
      chk("done_cmd_ready", {31'b0, cmd_ready}, 1);
      chained = 0;
    end
  endtask

  initial begin
    #1;
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 1);
    chk("rst_psel", {31'b0, psel}, 0);
    chk("rst_penable", {31'b0, penable}, 0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_pstrb", {28'b0, pstrb}, 0);
    @(negedge gclk); @(negedge gclk);
    grst_n = 1;

    // Unaligned write, no wait states.
    run_txn(32'h1000_4006, 0, 32'hA5A5_1234, 4'b0011, 0, 32'h0, 0, 0, 0);
    // Read with 3 wait states.
    run_txn(32'h2000_0010, 1, 32'h1111_2222, 4'hF, 3, 32'hDEAD_BEEF, 0, 0, 0);
    // Slave error on a read, then a clean one.
    run_txn(32'h2000_0020, 1, 32'h0, 4'h0, 1, 32'hCAFE_0001, 1, 0, 0);
    run_txn(32'h2000_0024, 1, 32'h0, 4'h0, 0, 32'h0BAD_F00D, 0, 0, 0);
    // Response backpressure 5 cycles, then overlap with the next command.
    run_txn(32'h3000_0000, 0, 32'h0123_4567, 4'hF, 0, 32'h0, 0, 5, 1);
    run_txn(32'h3000_0004, 1, 32'h0, 4'h0, 0, 32'h7654_3210, 0, 0, 1);
    run_txn(32'h3000_0008, 0, 32'h89AB_CDEF, 4'b1000, 0, 32'h0, 1, 0, 0);

    // Randomized transfers.
    for (int t = 0; t < 40; t++) begin
      run_txn($urandom, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3),
              $urandom, 1'($urandom_range(0, 3) == 0), $urandom_range(0, 2),
              (t != 39) && ($urandom_range(0, 1) == 1));
    end

    // Reset during ACCESS.
    @(negedge gclk);
    cmd_valid = 1; cmd_addr = 32'h4000_0000; cmd_read = 1;
    @(negedge gclk);
    cmd_valid = 0;
    @(negedge gclk);
    chk("pre_rst_penable", {31'b0, penable}, 1);
    #2 grst_n = 0;
    #1;
    chk("arst_psel", {31'b0, psel}, 0);
    chk("arst_penable", {31'b0, penable}, 0);
    chk("arst_paddr", paddr, 0);
    chk("arst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("arst_cmd_ready", {31'b0, cmd_ready}, 1);
    @(negedge gclk);
    grst_n = 1;
    @(negedge gclk);
    chk("post_rst_cmd_ready", {31'b0, cmd_ready}, 1);
    chk("post_rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("post_rst_psel", {31'b0, psel}, 0);

    // Slave that never answers.
    cmd_valid = 1; cmd_addr = 32'h5000_0008; cmd_read = 1;
    @(negedge gclk);
    cmd_valid = 0;
    prdata = 32'h5555_AAAA;
`ifdef E203_ICB2APB_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      @(negedge gclk);
      chk("to_penable", {31'b0, penable}, 1);
    end
    @(negedge gclk);
    chk("to_rsp_valid", {31'b0, rsp_valid}, 1);
    chk("to_rsp_err", {31'b0, rsp_err}, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    chk("to_psel", {31'b0, psel}, 0);
`else
    for (int i = 0; i < 40; i++) begin
      @(negedge gclk);
      chk("stuck_penable", {31'b0, penable}, 1);
      chk("stuck_rsp_valid", {31'b0, rsp_valid}, 0);
    end
    pready = 1; pslverr = 0;
    @(negedge gclk);
    pready = 0;
    chk("late_rsp_valid", {31'b0, rsp_valid}, 1);
    chk("late_rsp_rdata", rsp_rdata, 32'h5555_AAAA);
`endif
    rsp_ready = 1;
    @(negedge gclk);
    rsp_ready = 0;
    chk("end_cmd_ready", {31'b0, cmd_ready}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
